// File: rtl/riscv_mdu.sv
// rtl/riscv_mdu.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module riscv_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             N,
    output logic             Z
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, smin;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] spec_res;

    assign smin     = {1'b1, {(WIDTH-1){1'b0}}};
    assign a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                      (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b000) || (op == 3'b001) ||
                      (op == 3'b100) || (op == 3'b110);
    assign a_neg    = a_signed && a[WIDTH-1];
    assign b_neg    = b_signed && b[WIDTH-1];
    assign mag_a    = a_neg ? -a : a;
    assign mag_b    = b_neg ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == smin) && (b == '1);
    assign spec_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : smin);

    // acc holds {product hi, multiplier/product lo} or {remainder, dividend/quotient}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fix;
    logic [WIDTH:0]     div_sh, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_sel, div_fix, mul_sel, final_res;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fix  = neg_q ? -mul_next : mul_next;
    assign mul_sel  = (op_q[1:0] == 2'b00) ? mul_fix[WIDTH-1:0] : mul_fix[2*WIDTH-1:WIDTH];

    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign div_sel  = op_q[1] ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
    assign div_fix  = neg_q ? -div_sel : div_sel;

    assign final_res = op_q[2] ? div_fix : mul_sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            RUN: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = FIN;
                    result_d = final_res;
                    dbz_d    = 1'b0;
                end
            end
            default: begin
                if (start) begin
                    op_d  = op;
                    neg_d = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero || div_ovf) begin
                        state_d  = FIN;
                        result_d = spec_res;
                        dbz_d    = div_zero;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
                        opnd_d  = op[2] ? mag_b : mag_a;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign N           = result_q[WIDTH-1];
    assign Z           = (result_q == '0);
endmodule

// File: tb/tb_riscv_mdu.sv
// tb/tb_riscv_mdu.sv - scoreboard bench for riscv_mdu at WIDTH=32 and WIDTH=8
module tb_riscv_mdu;
    typedef logic signed [127:0] big_t;
    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          busy_n;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32, start8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32, result32;
    logic [7:0]  a8, b8, result8;
    logic        busy32, done32, dbz32, n32, z32;
    logic        busy8, done8, dbz8, n8, z8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ndone32 = 0;
    int busy_run32 = 0;
    int busy_run8 = 0;
    exp_t q32[$];
    exp_t q8[$];

    riscv_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .div_by_zero(dbz32),
        .N(n32), .Z(z32)
    );

    riscv_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .div_by_zero(dbz8),
        .N(n8), .Z(z8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    // Plain-arithmetic RV32M semantics on wide signed integers
    function automatic logic [32:0] ref_mdu(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m = wmask(w);
        big_t ua, ub, sa, sb, r;
        ua = '0;
        ub = '0;
        ua[31:0] = a & m;
        ub[31:0] = b & m;
        sa = ua[w-1] ? ua - (big_t'(1) <<< w) : ua;
        sb = ub[w-1] ? ub - (big_t'(1) <<< w) : ub;
        case (op)
            3'b000:  r = sa * sb;
            3'b001:  r = (sa * sb) >>> w;
            3'b010:  r = (sa * ub) >>> w;
            3'b011:  r = (ua * ub) >>> w;
            3'b100:  r = (ub == 0) ? -1 : sa / sb;
            3'b101:  r = (ub == 0) ? -1 : ua / ub;
            3'b110:  r = (ub == 0) ? ua : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return {op[2] && (ub == 0), r[31:0] & m};
    endfunction

    function automatic exp_t mk_exp(input int w, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] r = ref_mdu(w, op, a, b);
        logic [31:0] m = wmask(w);
        logic sp;
        sp = op[2] && (((b & m) == 0) ||
             (!op[0] && ((a & m) == (32'h1 << (w - 1))) && ((b & m) == m)));
        e.res    = r[31:0];
        e.dbz    = r[32];
        e.lat    = sp ? 1 : w + 1;
        e.busy_n = sp ? 0 : w;
        e.cyc    = 0;
        return e;
    endfunction

    function automatic logic [31:0] rnd_val(input int w);
        logic [31:0] m = wmask(w);
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return m;
            3:       return 32'h1 << (w - 1);
            4:       return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run32 = 0;
        end else begin
            if (busy32) busy_run32++;
            if (done32) begin
                exp_t e;
                ndone32++;
                if (q32.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done32_unexpected actual=%h expected=none", result32);
                end else begin
                    e = q32.pop_front();
                    chk("res32", result32, e.res);
                    chk("dbz32", {31'b0, dbz32}, {31'b0, e.dbz});
                    chk("n32", {31'b0, n32}, {31'b0, e.res[31]});
                    chk("z32", {31'b0, z32}, {31'b0, e.res == 0});
                    chk("lat32", 32'(cyc - e.cyc), 32'(e.lat));
                    chk("busycyc32", 32'(busy_run32), 32'(e.busy_n));
                end
                busy_run32 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run8 = 0;
        end else begin
            if (busy8) busy_run8++;
            if (done8) begin
                exp_t e;
                if (q8.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done8_unexpected actual=%h expected=none", result8);
                end else begin
                    e = q8.pop_front();
                    chk("res8", {24'b0, result8}, e.res);
                    chk("dbz8", {31'b0, dbz8}, {31'b0, e.dbz});
                    chk("nz8", {30'b0, n8, z8}, {30'b0, e.res[7], e.res == 0});
                    chk("lat8", 32'(cyc - e.cyc), 32'(e.lat));
                    chk("busycyc8", 32'(busy_run8), 32'(e.busy_n));
                end
                busy_run8 = 0;
            end
        end
    end

    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input exp_t e);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy32 && n < 200);
        if (busy32) begin fail_now("issue32_wait_idle"); return; end
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        e.cyc = cyc;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int n = 0;
        do begin @(negedge clk); n++; end while (busy8 && n < 100);
        if (busy8) begin fail_now("issue8_wait_idle"); return; end
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        e = mk_exp(8, op, {24'b0, a}, {24'b0, b});
        e.cyc = cyc;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic dir32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dbz);
        exp_t e = mk_exp(32, op, a, b);
        e.res = res;
        e.dbz = dbz;
        issue32(op, a, b, e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            fail_now("drain");
            q32.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic hold_test();
        exp_t e1, e2;
        int n = 0;
        do begin @(negedge clk); n++; end while (busy32 && n < 200);
        op32 = 3'b001; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; start32 = 1'b1;
        e1 = mk_exp(32, op32, a32, b32);
        e1.cyc = cyc;
        q32.push_back(e1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done32) begin
                op32 = 3'($urandom);
                a32  = $urandom;
                b32  = $urandom;
            end
        end while (!done32 && n < 100);
        if (!done32) begin
            fail_now("hold_done");
            start32 = 1'b0;
            return;
        end
        op32 = 3'b110; a32 = 32'hFFFF_FF9C; b32 = 32'd7;
        e2 = mk_exp(32, op32, a32, b32);
        e2.cyc = cyc;
        q32.push_back(e2);
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_result", result32, e1.res);
        chk("busy_b2b", {31'b0, busy32}, 32'h1);
    endtask

    initial begin
        logic [7:0] cv [8];
        int d0;
        cv = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
        start32 = 0; start8 = 0; op32 = 0; op8 = 0;
        a32 = 0; b32 = 0; a8 = 0; b8 = 0;
        #1;
        chk("rst_busy_done32", {30'b0, busy32, done32}, 32'h0);
        chk("rst_res32", result32, 32'h0);
        chk("rst_flags32", {29'b0, dbz32, n32, z32}, 32'h1);
        chk("rst_res8", {24'b0, result8}, 32'h0);
        chk("rst_flags8", {27'b0, busy8, done8, dbz8, n8, z8}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        dir32(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        dir32(3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        dir32(3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0);
        dir32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        dir32(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        dir32(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        dir32(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        dir32(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        dir32(3'b101, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1);
        dir32(3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1);
        dir32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        dir32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        drain();

        hold_test();
        drain();

        // Abort an in-flight multiply with an asynchronous reset
        dir32(3'b000, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {30'b0, busy32, done32}, 32'h0);
        chk("abort_res", result32, 32'h0);
        chk("abort_flags", {29'b0, dbz32, n32, z32}, 32'h1);
        q32.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0 = ndone32;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(ndone32 - d0), 32'h0);

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [2:0]  op;
                    logic [31:0] a, b;
                    op = 3'($urandom);
                    a  = rnd_val(32);
                    b  = rnd_val(32);
                    issue32(op, a, b, mk_exp(32, op, a, b));
                end
            end
            begin
                for (int o = 0; o < 8; o++)
                    for (int i = 0; i < 8; i++)
                        for (int j = 0; j < 8; j++)
                            issue8(3'(o), cv[i], cv[j]);
                for (int i = 0; i < 2500; i++)
                    issue8(3'($urandom), 8'(rnd_val(8)), 8'(rnd_val(8)));
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
